// File: rtl/prio_enc_pkg.sv
// Shared types and helpers for the sequential priority encoder.
// Holds size defaults, the FSM state type and a popcount helper.
package prio_enc_pkg;

   localparam int N_DEF = 8;
   localparam int W_DEF = $clog2(N_DEF);
   localparam int MAXN  = 256;

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   function automatic logic [15:0] popcount(input logic [MAXN-1:0] v);
      logic [15:0] c;
      c = '0;
      for (int i = 0; i < MAXN; i++) begin
         c = c + 16'(v[i]);
      end
      return c;
   endfunction

endpackage

// File: rtl/prio_enc_n.sv
// Combinational lowest-set-bit encoder.
// o_idx is the lowest set index; o_found flags a non-zero vector.
module prio_enc_n
   import prio_enc_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = W_DEF
) (
   input  logic [N-1:0] i_vec,
   output logic         o_found,
   output logic [W-1:0] o_idx
);

   always_comb begin
      o_found = |i_vec;
      o_idx   = '0;
      // Descending scan so the lowest set bit is written last.
      for (int i = N - 1; i >= 0; i--) begin
         if (i_vec[i]) begin
            o_idx = W'(i);
         end
      end
   end

endmodule

// File: rtl/priority_encoder_seq.sv
// Sequential priority encoder: accumulates request pulses and issues
// one binary index per valid/ready handshake, lowest index first.
module priority_encoder_seq
   import prio_enc_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         clr,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [N-1:0] pending,
   output logic [W:0]   pend_cnt,
   output logic         dup
);

   state_t          r_state;
   state_t          w_state_nxt;
   logic [N-1:0]    r_pend;
   logic [N-1:0]    w_pend_nxt;
   logic [N-1:0]    w_served;
   logic [N-1:0]    w_new;
   logic [N-1:0]    w_dup_hit;
   logic [W-1:0]    r_idx;
   logic [W-1:0]    w_sel;
   logic [W:0]      r_cnt;
   logic            r_dup;
   logic            w_found;
   logic            w_load;
   logic [MAXN-1:0] w_pad;

   always_comb begin
      w_served = '0;
      if (r_state == PRESENT && out_ready) begin
         w_served[r_idx] = 1'b1;
      end
   end

   assign w_new      = req & {N{en}};
   assign w_pend_nxt = (r_pend & ~w_served) | w_new;
   // A bit served this edge and re-requested is a fresh issue.
   assign w_dup_hit  = w_new & r_pend & ~w_served;

   prio_enc_n #(
      .N (N),
      .W (W)
   ) u_enc (
      .i_vec   (w_pend_nxt),
      .o_found (w_found),
      .o_idx   (w_sel)
   );

   always_comb begin
      w_pad           = '0;
      w_pad[N-1:0]    = w_pend_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               w_load      = 1'b1;
               w_state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            // No preemption: the presented index holds until consumed.
            if (out_ready) begin
               if (w_found) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = IDLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
         r_idx  <= '0;
         r_cnt  <= '0;
         r_dup  <= 1'b0;
      end else begin
         r_pend <= w_pend_nxt;
         r_cnt  <= (W+1)'(popcount(w_pad));
         if (w_load) begin
            r_idx <= w_sel;
         end
         if (|w_dup_hit) begin
            r_dup <= 1'b1;
         end else if (clr) begin
            r_dup <= 1'b0;
         end
      end
   end

   assign out_valid = (r_state == PRESENT);
   assign out_idx   = r_idx;
   assign pending   = r_pend;
   assign pend_cnt  = r_cnt;
   assign dup       = r_dup;

endmodule

// File: tb/tb_priority_encoder_seq.sv
// Self-checking bench: directed vector table, async reset case,
// then randomized traffic against a behavioural reference model.
module tb_priority_encoder_seq;

   logic       clk;
   logic       rst;
   logic       en;
   logic [7:0] req;
   logic       clr;
   logic       out_ready;
   logic       out_valid;
   logic [2:0] out_idx;
   logic [7:0] pending;
   logic [3:0] pend_cnt;
   logic       dup;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic       en;
      logic [7:0] req;
      logic       rdy;
      logic       clr;
      logic       v;
      logic [2:0] idx;
      logic [7:0] pend;
      logic [3:0] cnt;
      logic       dup;
   } vec_t;

   vec_t tv[$];

   priority_encoder_seq dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .req       (req),
      .clr       (clr),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_idx   (out_idx),
      .pending   (pending),
      .pend_cnt  (pend_cnt),
      .dup       (dup)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic v, input logic [2:0] idx,
                          input logic [7:0] pend, input logic [3:0] cnt,
                          input logic d);
      chk({tag, ".valid"}, int'(out_valid), int'(v));
      chk({tag, ".idx"}, int'(out_idx), int'(idx));
      chk({tag, ".pending"}, int'(pending), int'(pend));
      chk({tag, ".cnt"}, int'(pend_cnt), int'(cnt));
      chk({tag, ".dup"}, int'(dup), int'(d));
   endtask

   task automatic add(input logic e, input logic [7:0] r, input logic rd,
                      input logic c, input logic v, input logic [2:0] ix,
                      input logic [7:0] p, input logic [3:0] n, input logic d);
      vec_t t;
      t.en = e; t.req = r; t.rdy = rd; t.clr = c;
      t.v = v; t.idx = ix; t.pend = p; t.cnt = n; t.dup = d;
      tv.push_back(t);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Reference model state
   logic [7:0] m_pend;
   logic       m_valid;
   logic [2:0] m_idx;
   logic       m_dup;

   function automatic int lowest(input logic [7:0] v);
      for (int i = 0; i < 8; i++) begin
         if (v[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step(input logic e, input logic [7:0] r,
                             input logic rd, input logic c);
      logic [7:0] served;
      logic [7:0] nw;
      logic [7:0] nxt;
      served = (m_valid && rd) ? (8'd1 << m_idx) : 8'd0;
      nw     = e ? r : 8'd0;
      nxt    = (m_pend & ~served) | nw;
      if ((nw & m_pend & ~served) != 0) m_dup = 1'b1;
      else if (c) m_dup = 1'b0;
      if (!m_valid || rd) begin
         if (nxt != 0) begin
            m_valid = 1'b1;
            m_idx   = 3'(lowest(nxt));
         end else begin
            m_valid = 1'b0;
         end
      end
      m_pend = nxt;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; req = '0; clr = 1'b0; out_ready = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      cycle();
      chk_all("reset", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);

      // burst
      add(1, 8'hA4, 1, 0, 1, 3'd2, 8'hA4, 4'd3, 0);
      add(1, 8'h00, 1, 0, 1, 3'd5, 8'hA0, 4'd2, 0);
      add(1, 8'h00, 1, 0, 1, 3'd7, 8'h80, 4'd1, 0);
      add(1, 8'h00, 1, 0, 0, 3'd7, 8'h00, 4'd0, 0);
      // backpressure, no preemption
      add(1, 8'h20, 0, 0, 1, 3'd5, 8'h20, 4'd1, 0);
      add(1, 8'h02, 0, 0, 1, 3'd5, 8'h22, 4'd2, 0);
      add(1, 8'h00, 1, 0, 1, 3'd1, 8'h02, 4'd1, 0);
      add(1, 8'h00, 1, 0, 0, 3'd1, 8'h00, 4'd0, 0);
      // duplicate then clear
      add(1, 8'h08, 0, 0, 1, 3'd3, 8'h08, 4'd1, 0);
      add(1, 8'h08, 0, 0, 1, 3'd3, 8'h08, 4'd1, 1);
      add(1, 8'h00, 1, 0, 0, 3'd3, 8'h00, 4'd0, 1);
      add(1, 8'h00, 0, 1, 0, 3'd3, 8'h00, 4'd0, 0);
      // serve and re-request
      add(1, 8'h10, 1, 0, 1, 3'd4, 8'h10, 4'd1, 0);
      add(1, 8'h10, 1, 0, 1, 3'd4, 8'h10, 4'd1, 0);
      add(1, 8'h00, 1, 0, 0, 3'd4, 8'h00, 4'd0, 0);
      // enable gating
      add(0, 8'hFF, 1, 0, 0, 3'd4, 8'h00, 4'd0, 0);
      add(0, 8'hFF, 1, 0, 0, 3'd4, 8'h00, 4'd0, 0);
      add(0, 8'hFF, 1, 0, 0, 3'd4, 8'h00, 4'd0, 0);
      add(1, 8'h80, 1, 0, 1, 3'd7, 8'h80, 4'd1, 0);
      add(1, 8'h00, 1, 0, 0, 3'd7, 8'h00, 4'd0, 0);
      // clr together with a new duplicate: set wins
      add(1, 8'h01, 0, 0, 1, 3'd0, 8'h01, 4'd1, 0);
      add(1, 8'h01, 0, 1, 1, 3'd0, 8'h01, 4'd1, 1);
      add(1, 8'h00, 1, 1, 0, 3'd0, 8'h00, 4'd0, 0);

      foreach (tv[k]) begin
         en = tv[k].en; req = tv[k].req;
         out_ready = tv[k].rdy; clr = tv[k].clr;
         cycle();
         chk_all($sformatf("vec%0d", k), tv[k].v, tv[k].idx,
                 tv[k].pend, tv[k].cnt, tv[k].dup);
      end

      // asynchronous reset mid-cycle with work in flight
      en = 1'b1; req = 8'hA4; out_ready = 1'b0; clr = 1'b0;
      cycle();
      req = 8'h00;
      chk("pre_rst.pending", int'(pending), 32'hA4);
      #2;
      rst = 1'b1;
      #1;
      chk_all("async_rst", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
      cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 2; k++) begin
         cycle();
         chk_all($sformatf("post_rst%0d", k), 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
      end

      // randomized traffic against the model
      m_pend = '0; m_valid = 1'b0; m_idx = '0; m_dup = 1'b0;
      for (int k = 0; k < 400; k++) begin
         en        = ($urandom_range(0, 9) < 8);
         req       = 8'($urandom) & 8'($urandom) & 8'($urandom);
         out_ready = ($urandom_range(0, 9) < 6);
         clr       = ($urandom_range(0, 9) == 0);
         cycle();
         model_step(en, req, out_ready, clr);
         chk_all($sformatf("rnd%0d", k), m_valid, m_idx, m_pend,
                 4'($countones(m_pend)), m_dup);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/priority_encoder_seq.md
# priority_encoder_seq

Sequential N-to-log2(N) priority encoder, the encoding counterpart to the team's 2-to-4/N-way decoders. It accumulates request pulses into a pending vector and issues one encoded index at a time over a valid/ready handshake, lowest index first. It clears each bit once the index is consumed. It sits between event sources (interrupt lines, channel flags) and a consumer that needs a binary channel number, for example a decoder that drives the per-channel acknowledge.

## Interface
- N, default 8: number of request lines. Power of two, ≥ 2.
- W, default $clog2(N): index width.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  request enable; when low, `req` is ignored.
- req  in  N  request pulses; bit i set at an edge marks index i pending.
- clr  in  1  synchronous clear of the sticky `dup` flag.
- out_ready  in  1  consumer accepts `out_idx` this cycle.
- out_valid  out  1  `out_idx` is valid.
- out_idx  out  W  encoded index of the presented request.
- pending  out  N  registered pending vector. Includes the presented index until it is consumed.
- pend_cnt  out  W+1  popcount of `pending`.
- dup  out  1  sticky flag: a request arrived for an index already pending.

## Operation
- Reset asserted: pending=0, out_valid=0, out_idx=0, pend_cnt=0, dup=0, state=IDLE. Takes effect immediately and is independent of clk. This also applies mid-stream: in-flight indices are discarded.
- Per edge:
  - served = onehot(out_idx) when out_valid & out_ready, else 0.
  - new = req & {N{en}}.
  - pending_next = (pending & ~served) | new.
- Selection is combinational: the lowest-index set bit of pending_next. `found` is high when pending_next ≠ 0.
- FSM has two states, IDLE (out_valid=0) and PRESENT (out_valid=1).
  - IDLE: if `found`, load out_idx=sel and go to PRESENT. Otherwise stay.
  - PRESENT, out_ready=0: hold out_idx and out_valid. There is no preemption, even if a lower index arrives.
  - PRESENT, out_ready=1: if `found`, load out_idx=sel and stay in PRESENT. Otherwise go to IDLE. out_idx keeps its last value in IDLE.
- Duplicates: if new[i] & pending[i] & ~served[i], set dup=1. The request coalesces into a single issue.
- A bit that is served and re-requested in the same cycle stays pending. It is re-issued and does not set `dup`.
- clr and a new duplicate in the same cycle: set wins (dup=1).
- pend_cnt = popcount(pending), registered alongside `pending`. Range is 0..N, which needs W+1 bits.
- en=0 blocks new requests only. Pending entries keep draining.

## Timing
- Latency: a req bit sampled at edge t in IDLE gives out_valid=1 with its index after edge t (1 cycle).
- Throughput: one index per cycle while out_ready=1.
- A handshake completes at a rising edge where out_valid & out_ready are both high. The next index, if any, is presented after that same edge, with no bubble.
- out_idx is stable whenever out_valid=1 and out_ready=0.
- All outputs are registered, so there are no combinational paths from inputs to outputs.

## Structure
- Shared package `prio_enc_pkg`: N/W defaults, FSM state typedef (IDLE, PRESENT), and a popcount function.
- Sub-module `prio_enc_n`: combinational lowest-set-bit encoder, parameterised on N, with outputs {found, idx}. The top holds the registers, FSM, dup logic and count.

## Test plan
- Reset: assert rst asynchronously mid-cycle with pending=8'hA4 → all outputs read 0 immediately. After release, there is no issue without new req.
- Burst: req=8'b1010_0100 for one cycle, en=1, out_ready=1 → out_idx 2, 5, 7 on three consecutive cycles with out_valid=1. pend_cnt reads 3, 2, 1, then 0. out_valid=0 on the 4th cycle.
- Backpressure: 5 is presented with out_ready=0, then req bit 1 arrives → out_idx stays 5 and pending=8'h22. When out_ready=1, 5 is consumed, then 1 is issued.
- Duplicate: index 3 is pending and not consumed, then req bit 3 again → dup=1 and 3 is issued exactly once. clr=1 → dup=0 on the next cycle.
- Serve-and-rerequest: 4 is presented with out_ready=1, and req bit 4 arrives in the same cycle → 4 is issued again on the next cycle and dup stays 0.
- Enable: en=0 with req=8'hFF for 3 cycles → pending=0 and out_valid=0. Then en=1 with req=8'h80 → out_idx=7 after 1 cycle.
